risc16_trace_buffer: RTL

//  Synthesisable execution-trace capture for the RiSC-16 core: records one entry per retired

---
 rtl/risc16_trace_buffer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/risc16_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : risc16_trace_buffer
//  Description : Execution-trace capture for the RiSC-16 core. Records one
//                entry per retired instruction {we, rdst, wdata, instr, pc}
//                into a circular buffer. A PC-match trigger starts a
//                post-trigger window. Stop and wrap modes set what happens
//                when the buffer is full. The trace is read out through a
//                valid/ready port, oldest entry first.
//  Ports       : clk, rst_n (async, active-low)
//                arm_i / stop_i        run control pulses (arm > stop)
//                mode_wrap_i           1 = overwrite oldest, 0 = stop on full
//                trig_en_i, trig_pc_i  PC-match trigger
//                cap_*_i               retired-instruction capture port
//                rd_valid_o/rd_ready_i/rd_data_o  readout handshake (DONE)
//                count_o, state_o, triggered_o, overflow_o  status
//  Revision    : 1.0  initial release
// ============================================================================
module risc16_trace_buffer #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arm_i,
    input  logic                         stop_i,
    input  logic                         mode_wrap_i,
    input  logic                         trig_en_i,
    input  logic [DATA_W-1:0]            trig_pc_i,
    input  logic                         cap_valid_i,
    input  logic [DATA_W-1:0]            cap_pc_i,
    input  logic [DATA_W-1:0]            cap_instr_i,
    input  logic                         cap_we_i,
    input  logic [2:0]                   cap_rdst_i,
    input  logic [DATA_W-1:0]            cap_wdata_i,
    output logic                         rd_valid_o,
    input  logic                         rd_ready_i,
    output logic [3*DATA_W+3:0]          rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [1:0]                   state_o,
    output logic                         triggered_o,
    output logic                         overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = 3*DATA_W+4;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] NEAR_FULL  = CW'(DEPTH-1);
    localparam logic [PW-1:0] POST_INIT  = PW'(POST_CNT);
    localparam logic [PW-1:0] POST_LAST  = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   post_q, post_d;
    logic            triggered_q, triggered_d;
    logic            overflow_q, overflow_d;
    logic            wr_en;
    logic            full;
    logic            hit;
    logic [EW-1:0]   mem_q [DEPTH];

    assign full       = (count_q == FULL_CNT);
    assign hit        = trig_en_i && (cap_pc_i == trig_pc_i);
    assign rd_valid_o = (state_q == S_DONE) && (count_q != '0);
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign state_o    = state_q;
    assign triggered_o = triggered_q;
    assign overflow_o  = overflow_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        post_d      = post_q;
        triggered_d = triggered_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;

        if (arm_i) begin
            state_d     = S_ARMED;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            post_d      = '0;
            triggered_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            case (state_q)
                S_ARMED, S_POST: begin
                    if (cap_valid_i && full && !mode_wrap_i) begin
                        // Full in stop mode: the capture is dropped.
                        state_d = S_DONE;
                    end else if (cap_valid_i) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (full) begin
                            // Wrap: the new entry replaces the oldest one.
                            rd_ptr_d   = rd_ptr_q + 1'b1;
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                        if (stop_i) begin
                            state_d = S_DONE;
                        end else begin
                            if (state_q == S_ARMED && hit) begin
                                triggered_d = 1'b1;
                                if (POST_CNT == 0) begin
                                    state_d = S_DONE;
                                end else begin
                                    state_d = S_POST;
                                    post_d  = POST_INIT;
                                end
                            end else if (state_q == S_POST) begin
                                post_d = post_q - 1'b1;
                                if (post_q == POST_LAST) state_d = S_DONE;
                            end
                            // In stop mode, stop on the edge the buffer fills.
                            if (!mode_wrap_i && count_q == NEAR_FULL) state_d = S_DONE;
                        end
                    end else if (stop_i) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (rd_valid_o && rd_ready_i) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            post_q      <= post_d;
            triggered_q <= triggered_d;
            overflow_q  <= overflow_d;
        end
    end

    // Trace storage is not reset; count and pointers define valid content.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {cap_we_i, cap_rdst_i, cap_wdata_i, cap_instr_i, cap_pc_i};
        end
    end

endmodule
`default_nettype wire
